// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
//   ctrl_state_t : controller state (RUN, DISCARD)
//   REG_X0       : architectural zero register, never a real hazard source
//   BUBBLE       : value loaded into a pipeline register on flush
package pipeline_ctrl_pkg;

  typedef enum logic {RUN, DISCARD} ctrl_state_t;

  localparam logic [4:0]  REG_X0 = 5'd0;
  localparam logic [31:0] BUBBLE = 32'h00000000;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the instruction in ID and a
// load in EX.
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : ID source operands and usage
//   ex_rd, ex_mem_read                     : EX destination and load flag
//   load_use                               : ID needs a value the EX load has not produced yet
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic w_rs1_hit, w_rs2_hit;

  assign w_rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  // x0 writes are discarded, so a "load to x0" never creates a dependency.
  assign load_use  = ex_mem_read && (ex_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
//   clk, reset (sync, active-high)
//   ID/EX hazard inputs, ex_branch_taken, imem_valid, mem_req/mem_ready
//   pc_write_en, pc_redirect, per-register write_en / flush controls
//   stall_cnt (cycles with PC frozen), flush_cnt (taken-branch redirects)
// Controls are combinational from state and inputs; the DISCARD state drops
// the fetch response that was in flight when a redirect happened.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             imem_valid,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write_en,
  output logic             pc_redirect,
  output logic             if_id_write_en,
  output logic             id_ex_write_en,
  output logic             ex_mem_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_load_use, w_mem_wait, w_stall_inc, w_flush_inc;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (w_load_use)
  );

  assign w_mem_wait = mem_req && !mem_ready;

  always_comb begin
    pc_write_en     = 1'b1;
    pc_redirect     = 1'b0;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    mem_wb_flush    = 1'b0;
    w_stall_inc     = 1'b0;
    w_flush_inc     = 1'b0;
    w_state_nxt     = r_state;
    if (reset) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
      mem_wb_flush    = 1'b1;
      w_state_nxt     = RUN;
    end else if (w_mem_wait) begin
      // Freeze IF..EX, let MEM hold, and push a bubble into WB.
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_flush    = 1'b1;
      w_stall_inc     = 1'b1;
    end else if (ex_branch_taken) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_flush_inc = 1'b1;
      // The fetch for the wrong-path PC is still outstanding; its response
      // must be dropped when it eventually arrives.
      if (r_state == RUN && !imem_valid) w_state_nxt = DISCARD;
    end else if (w_load_use) begin
      // Hold IF/ID so the dependent instruction re-decodes next cycle.
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
      w_stall_inc    = 1'b1;
    end else if (r_state == DISCARD) begin
      pc_write_en = 1'b0;
      if_id_flush = 1'b1;
      w_stall_inc = 1'b1;
      if (imem_valid) w_state_nxt = RUN;
    end else if (!imem_valid) begin
      pc_write_en = 1'b0;
      if_id_flush = 1'b1;
      w_stall_inc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic             imem_valid, mem_req, mem_ready;
  logic             pc_write_en, pc_redirect, if_id_write_en, id_ex_write_en;
  logic             ex_mem_write_en, if_id_flush, id_ex_flush, mem_wb_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .imem_valid(imem_valid),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write_en(pc_write_en), .pc_redirect(pc_redirect),
    .if_id_write_en(if_id_write_en), .id_ex_write_en(id_ex_write_en),
    .ex_mem_write_en(ex_mem_write_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: discarding a stale fetch, plus counters as plain integers.
  bit m_disc = 1'b0;
  int m_stall = 0;
  int m_flush = 0;
  logic [7:0] last_vec;

  // Control vector: {pc_we, redirect, if_id_we, id_ex_we, ex_mem_we, if_id_fl, id_ex_fl, mem_wb_fl}
  // Event codes: 0 none, 1 reset, 2 mem wait, 3 branch, 4 load-use, 5 fetch starve/drop
  function automatic logic [7:0] ev_vec(int ev);
    case (ev)
      1:       return 8'b00000111;
      2:       return 8'b00000001;
      3:       return 8'b11111110;
      4:       return 8'b00011010;
      5:       return 8'b00111100;
      default: return 8'b10111000;
    endcase
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic idle();
    reset = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_mem_read = 0; ex_branch_taken = 0;
    imem_valid = 1; mem_req = 0; mem_ready = 1;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    int  ev;
    bit  lu;
    #1;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (reset)                            ev = 1;
    else if (mem_req && !mem_ready)       ev = 2;
    else if (ex_branch_taken)             ev = 3;
    else if (lu)                          ev = 4;
    else if (m_disc || !imem_valid)       ev = 5;
    else                                  ev = 0;
    last_vec = {pc_write_en, pc_redirect, if_id_write_en, id_ex_write_en,
                ex_mem_write_en, if_id_flush, id_ex_flush, mem_wb_flush};
    chk("ctrl_vec", {24'd0, last_vec}, {24'd0, ev_vec(ev)});
    chk("stall_cnt", {24'd0, stall_cnt}, m_stall);
    chk("flush_cnt", {24'd0, flush_cnt}, m_flush);
    @(posedge clk);
    if (ev == 1) begin
      m_disc = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (ev == 2 || ev == 4 || ev == 5) m_stall = (m_stall + 1) % (1 << CNT_W);
      if (ev == 3) begin
        m_flush = (m_flush + 1) % (1 << CNT_W);
        if (!m_disc && !imem_valid) m_disc = 1;
      end
      if (ev == 5 && m_disc && imem_valid) m_disc = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    idle(); reset = 1;
    repeat (n) step();
    reset = 0;
  endtask

  initial begin
    idle();
    @(negedge clk);

    // Reset held mid-DISCARD.
    do_reset(1);
    idle(); ex_branch_taken = 1; imem_valid = 0; step();
    idle(); imem_valid = 0; reset = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ctrl", {24'd0, last_vec}, 32'h07);
    end
    idle();
    chk("rst_stall0", {24'd0, stall_cnt}, 0);
    chk("rst_flush0", {24'd0, flush_cnt}, 0);
    step();
    chk("rst_to_run", {24'd0, last_vec}, 32'hB8);

    // Load-use on rs2, then same with ex_rd = x0.
    do_reset(1);
    idle(); ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1; step();
    chk("lu_ctrl", {24'd0, last_vec}, 32'h1A);
    chk("lu_stall", {24'd0, stall_cnt}, 1);
    ex_rd = 0; step();
    chk("lu_x0_ctrl", {24'd0, last_vec}, 32'hB8);
    chk("lu_x0_stall", {24'd0, stall_cnt}, 1);

    // Taken branch with fetch available.
    do_reset(1);
    idle(); ex_branch_taken = 1; step();
    chk("br_ctrl", {24'd0, last_vec}, 32'hFE);
    chk("br_flush", {24'd0, flush_cnt}, 1);
    idle(); step();
    chk("br_stays_run", {24'd0, last_vec}, 32'hB8);

    // Taken branch with fetch outstanding, then 0,0,1.
    do_reset(1);
    idle(); ex_branch_taken = 1; imem_valid = 0; step();
    idle(); imem_valid = 0; step();
    chk("disc1", {24'd0, last_vec}, 32'h3C);
    step();
    chk("disc2", {24'd0, last_vec}, 32'h3C);
    imem_valid = 1; step();
    chk("disc3", {24'd0, last_vec}, 32'h3C);
    chk("disc_stall", {24'd0, stall_cnt}, 3);
    step();
    chk("disc_run", {24'd0, last_vec}, 32'hB8);

    // Memory wait overrides pending branch and load-use.
    do_reset(1);
    idle(); mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mw_frozen", {24'd0, last_vec}, 32'h01);
    end
    mem_ready = 1; step();
    chk("mw_branch", {24'd0, last_vec}, 32'hFE);
    chk("mw_stall", {24'd0, stall_cnt}, 4);

    // Counter wrap: 255 stalls, then one more.
    do_reset(1);
    idle(); imem_valid = 0;
    repeat (255) step();
    chk("wrap_max", {24'd0, stall_cnt}, 255);
    step();
    chk("wrap_zero", {24'd0, stall_cnt}, 0);

    // Randomized traffic.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 59) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom);
      id_uses_rs2     = 1'($urandom);
      ex_mem_read     = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      imem_valid      = ($urandom_range(0, 9) < 6);
      mem_req         = 1'($urandom);
      mem_ready       = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RV32I pipeline. Each cycle it decides the PC write enable, PC redirect, and the write-enable and flush controls of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. Inputs are load-use hazards, taken branches/jumps resolved in EX, instruction-fetch latency and data-memory wait states. It also discards a stale fetch response after a redirect and keeps stall and flush event counters.

## Interface
- CNT_W, 32, width of the performance counters
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1 / rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- imem_valid  in  1  fetch response for current PC available this cycle
- mem_req  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_write_en  out  1  PC register loads next value
- pc_redirect  out  1  PC next-value mux selects EX branch target
- if_id_write_en, id_ex_write_en, ex_mem_write_en  out  1 each  register loads its input
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  register loads a bubble (all zero); flush overrides write_en
- stall_cnt  out  CNT_W  count of cycles with PC frozen
- flush_cnt  out  CNT_W  count of taken-branch redirects

## Operation
- States: RUN and DISCARD. The state is registered. Outputs are combinational from state and inputs (Mealy).
- load_use = ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).
- mem_wait = mem_req && !mem_ready.
- Defaults: all write_en = 1, all flush = 0, pc_redirect = 0.
- RUN, rules in priority order (first match wins):
  1. mem_wait: pc_write_en, if_id_write_en, id_ex_write_en and ex_mem_write_en = 0; mem_wb_flush = 1; stall_cnt++. The state is unchanged.
  2. ex_branch_taken: pc_redirect = 1, pc_write_en = 1, if_id_flush = 1, id_ex_flush = 1; flush_cnt++. If !imem_valid, next state is DISCARD.
  3. load_use: pc_write_en = 0, if_id_write_en = 0, id_ex_flush = 1; stall_cnt++.
  4. !imem_valid: pc_write_en = 0, if_id_flush = 1; stall_cnt++.
- DISCARD:
  - mem_wait has rule-1 behaviour and stays in DISCARD.
  - Otherwise: pc_write_en = 0, if_id_flush = 1, stall_cnt++. The fetch response is dropped.
  - When imem_valid = 1, next state is RUN.
  - ex_branch_taken or load_use in DISCARD applies the RUN rule 2/3 outputs, and the state stays DISCARD.
- Counters wrap modulo 2^CNT_W. When stall and flush are both counted in one cycle, both increment.
- While reset = 1: all write_en = 0, all flush = 1, pc_redirect = 0. Next state is RUN and counters clear to 0. Reset in DISCARD abandons the discard.

## Timing
- Controls are valid in the same cycle as their inputs (zero latency). Registers act on the next posedge.
- Load-use hazard: exactly 1 bubble in EX, after which forwarding covers the hazard.
- Taken branch: 2 bubbles (IF_ID and ID_EX flushed), plus DISCARD cycles if the fetch was outstanding.
- Memory wait of N cycles freezes IF through EX for N cycles and inserts N bubbles into WB.
- The state machine transitions only on posedge. No output depends on the previous cycle's inputs other than through the state.

## Structure
- Package pipeline_ctrl_pkg holds:
  - typedef enum logic {RUN, DISCARD} ctrl_state_t
  - localparam REG_X0 = 5'd0
  - localparam BUBBLE = 32'h00000000
- Sub-module hazard_detect: purely combinational load_use compare, reusable by a future forwarding unit.
- Top level holds the state register, the priority logic and the two counters.

## Test plan
- Reset held 3 cycles mid-DISCARD -> all flush = 1 and write_en = 0 during reset; after release state = RUN, stall_cnt = flush_cnt = 0.
- ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1, imem_valid = 1 -> one cycle of pc_write_en = 0, if_id_write_en = 0, id_ex_flush = 1; stall_cnt = 1. Same stimulus with ex_rd = 0 -> no stall.
- ex_branch_taken = 1, imem_valid = 1 -> pc_redirect = 1, if_id_flush = id_ex_flush = 1, flush_cnt = 1, state stays RUN.
- ex_branch_taken = 1 with imem_valid = 0, then imem_valid = 0, 0, 1 -> DISCARD for 3 cycles with if_id_flush = 1 and pc_write_en = 0; RUN afterwards; stall_cnt = 3.
- mem_req = 1, mem_ready = 0 for 4 cycles while ex_branch_taken = 1 and load_use active -> 4 cycles frozen with mem_wb_flush = 1 and no redirect. The branch redirect fires in cycle 5, when mem_ready = 1.
- stall_cnt preset near wrap (force to 2^CNT_W - 1) plus one stall -> stall_cnt = 0.
